// File: rtl/gpr_regfile_mp_pkg.sv
// rtl/gpr_regfile_mp_pkg.sv - shared types and sizing for the multi-read-port register file
package gpr_regfile_mp_pkg;

  localparam int NTHREADS = 4;
  localparam int NREGS    = 64;
  localparam int TidMSB   = $clog2(NTHREADS) - 1;
  localparam int RW       = $clog2(NREGS);
  localparam int AW       = TidMSB + 1 + RW;
  localparam int DEPTH    = NTHREADS * NREGS;

  typedef logic [31:0] value_t;

  typedef struct packed {
    logic [TidMSB:0] tid;
    logic [RW-1:0]   rg;
  } gpr_addr_t;

  typedef enum logic {ST_CLEAR, ST_RUN} rf_state_e;

  // An entry is live when its thread exists and it is not the hardwired r0.
  function automatic logic entry_ok(input gpr_addr_t a, input logic zero_r0);
    return (int'(a.tid) < NTHREADS) && !(zero_r0 && (a.rg == '0));
  endfunction

endpackage

// File: rtl/gpr_regfile_mp_bank.sv
// rtl/gpr_regfile_mp_bank.sv - gpr_bank: 1W1R byte-enabled block RAM, read-first synchronous read
module gpr_bank #(
  parameter int WID   = 32,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic [WID/8-1:0]  we,
  input  logic [AW-1:0]     waddr,
  input  logic [WID-1:0]    wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WID-1:0]    rdata
);

  (* ram_style = "block" *) logic [WID-1:0] mem [DEPTH];
  logic [WID-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < WID/8; b++) begin
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/gpr_regfile_mp.sv
// rtl/gpr_regfile_mp.sv - per-thread GPR file, one byte-enabled write port, NRDPORT read ports
// GPR_BYPASS_EN merges a same-edge write into colliding reads; otherwise collisions are read-first.
module gpr_regfile_mp
  import gpr_regfile_mp_pkg::*;
#(
  parameter int   NRDPORT = 3,
  parameter int   WID     = $bits(value_t),
  parameter logic ZERO_R0 = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WID/8-1:0]              wr,
  input  logic [AW-1:0]                 wa,
  input  logic [WID-1:0]                i,
  input  logic [NRDPORT-1:0][AW-1:0]    ra,
  output logic [NRDPORT-1:0][WID-1:0]   o,
  output logic                          rdy
);

  localparam int NB = WID / 8;
  localparam int CW = $clog2(DEPTH);

  rf_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NB-1:0] run_we, bank_we;
  logic [AW-1:0] bank_wa;
  logic [WID-1:0] bank_wd;
  logic [NRDPORT-1:0] rd_en_q, rd_en_d;
  logic [NRDPORT-1:0][WID-1:0] bank_rd;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run_we  = '0;
    bank_we = '0;
    bank_wa = wa;
    bank_wd = i;
    if ((state_q == ST_RUN) && entry_ok(gpr_addr_t'(wa), ZERO_R0)) run_we = wr;
    case (state_q)
      ST_CLEAR: begin
        bank_we = '1;
        bank_wa = AW'(cnt_q);
        bank_wd = '0;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(DEPTH - 1)) state_d = ST_RUN;
      end
      default: bank_we = run_we;
    endcase
    for (int p = 0; p < NRDPORT; p++) begin
      rd_en_d[p] = (state_q == ST_RUN) && entry_ok(gpr_addr_t'(ra[p]), ZERO_R0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      rd_en_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_en_q <= rd_en_d;
    end
  end

  for (genvar p = 0; p < NRDPORT; p++) begin : g_port
    gpr_bank #(.WID(WID), .DEPTH(DEPTH), .AW(AW)) u_bank (
      .clk   (clk),
      .we    (bank_we),
      .waddr (bank_wa),
      .wdata (bank_wd),
      .raddr (ra[p]),
      .rdata (bank_rd[p])
    );
  end

`ifdef GPR_BYPASS_EN
  logic [NRDPORT-1:0][NB-1:0] byp_we_q, byp_we_d;
  logic [WID-1:0] byp_data_q, byp_data_d;

  always_comb begin
    byp_data_d = i;
    for (int p = 0; p < NRDPORT; p++) begin
      byp_we_d[p] = (ra[p] == wa) ? run_we : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_we_q   <= '0;
      byp_data_q <= '0;
    end else begin
      byp_we_q   <= byp_we_d;
      byp_data_q <= byp_data_d;
    end
  end

  always_comb begin
    o = '0;
    for (int p = 0; p < NRDPORT; p++) begin
      for (int b = 0; b < NB; b++) begin
        if (rd_en_q[p]) begin
          o[p][8*b +: 8] = byp_we_q[p][b] ? byp_data_q[8*b +: 8] : bank_rd[p][8*b +: 8];
        end
      end
    end
  end
`else
  always_comb begin
    o = '0;
    for (int p = 0; p < NRDPORT; p++) begin
      if (rd_en_q[p]) o[p] = bank_rd[p];
    end
  end
`endif

  assign rdy = (state_q == ST_RUN);

endmodule

// File: tb/tb_gpr_regfile_mp.sv
// tb/tb_gpr_regfile_mp.sv - directed vector bench for gpr_regfile_mp (honours GPR_BYPASS_EN)
module tb_gpr_regfile_mp;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] wr;
  logic [7:0] wa;
  logic [31:0] i;
  logic [2:0][7:0] ra;
  logic [2:0][31:0] o;
  logic rdy;

  int n_cmp = 0;
  int n_bad = 0;
  logic byp;

  typedef struct {
    logic [3:0]       wr;
    logic [7:0]       wa;
    logic [31:0]      i;
    logic [2:0][7:0]  ra;
    logic [2:0][31:0] ex;
  } vec_t;

  vec_t vecs [11];

  gpr_regfile_mp #(.NRDPORT(3), .WID(32), .ZERO_R0(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .wr  (wr),
    .wa  (wa),
    .i   (i),
    .ra  (ra),
    .o   (o),
    .rdy (rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] ad(input int t, input int r);
    return {t[1:0], r[5:0]};
  endfunction

  function automatic vec_t mk(input logic [3:0] w, input logic [7:0] a, input logic [31:0] d,
                              input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                              input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.wr = w;
    v.wa = a;
    v.i  = d;
    v.ra = {r2, r1, r0};
    v.ex = {e2, e1, e0};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input string nm, input logic wr_in_clear);
    int n;
    n = 0;
    while (!rdy && n < 400) begin
      ra = {8'($urandom), 8'($urandom), 8'($urandom)};
      wr = wr_in_clear ? 4'hF : 4'h0;
      wa = ad(0, 9);
      i  = 32'h5555_5555;
      tick();
      n++;
      for (int p = 0; p < 3; p++) chk($sformatf("%s_clear_o%0d", nm, p), o[p], 32'h0);
    end
    wr = 4'h0;
    chk({nm, "_clear_cycles"}, 32'(n), 32'd256);
  endtask

  initial begin
`ifdef GPR_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    vecs[0]  = mk(4'hF, ad(1, 5),  32'hDEADBEEF, ad(0, 9),  ad(0, 9), ad(0, 9),
                  32'h0, 32'h0, 32'h0);
    vecs[1]  = mk(4'h0, ad(0, 0),  32'h0,        ad(1, 5),  ad(0, 5), ad(1, 5),
                  32'hDEADBEEF, 32'h0, 32'hDEADBEEF);
    vecs[2]  = mk(4'h2, ad(1, 5),  32'h0000AA00, ad(3, 0),  ad(3, 0), ad(3, 0),
                  32'h0, 32'h0, 32'h0);
    vecs[3]  = mk(4'h0, ad(0, 0),  32'h0,        ad(1, 5),  ad(1, 5), ad(2, 7),
                  32'hDEADAAEF, 32'hDEADAAEF, 32'h0);
    vecs[4]  = mk(4'hF, ad(2, 7),  32'h11111111, ad(0, 0),  ad(0, 0), ad(0, 0),
                  32'h0, 32'h0, 32'h0);
    vecs[5]  = mk(4'hF, ad(2, 7),  32'h12345678, ad(2, 7),  ad(2, 7), ad(1, 5),
                  byp ? 32'h12345678 : 32'h11111111,
                  byp ? 32'h12345678 : 32'h11111111, 32'hDEADAAEF);
    vecs[6]  = mk(4'hF, ad(3, 0),  32'hFFFFFFFF, ad(2, 7),  ad(2, 7), ad(2, 7),
                  32'h12345678, 32'h12345678, 32'h12345678);
    vecs[7]  = mk(4'h1, ad(1, 5),  32'h00000033, ad(3, 0),  ad(3, 0), ad(1, 5),
                  32'h0, 32'h0, byp ? 32'hDEADAA33 : 32'hDEADAAEF);
    vecs[8]  = mk(4'h0, ad(0, 0),  32'h0,        ad(1, 5),  ad(1, 5), ad(1, 5),
                  32'hDEADAA33, 32'hDEADAA33, 32'hDEADAA33);
    vecs[9]  = mk(4'hC, ad(3, 63), 32'hCAFEF00D, ad(3, 63), ad(0, 0), ad(1, 5),
                  byp ? 32'hCAFE0000 : 32'h0, 32'h0, 32'hDEADAA33);
    vecs[10] = mk(4'h0, ad(0, 0),  32'h0,        ad(0, 63), ad(3, 63), ad(3, 63),
                  32'h0, 32'hCAFE0000, 32'hCAFE0000);

    rst = 1'b1;
    wr  = 4'h0;
    wa  = 8'h0;
    i   = 32'h0;
    ra  = '0;
    repeat (3) tick();
    chk("reset_rdy", 32'(rdy), 32'd0);
    for (int p = 0; p < 3; p++) chk($sformatf("reset_o%0d", p), o[p], 32'h0);
    rst = 1'b0;

    wait_rdy("boot", 1'b1);

    for (int k = 0; k < 11; k++) begin
      wr = vecs[k].wr;
      wa = vecs[k].wa;
      i  = vecs[k].i;
      ra = vecs[k].ra;
      tick();
      for (int p = 0; p < 3; p++) chk($sformatf("vec%0d_o%0d", k, p), o[p], vecs[k].ex[p]);
    end
    wr = 4'h0;

    // Reset from RUN must blank the outputs on the very next edge.
    ra  = {ad(1, 5), ad(1, 5), ad(1, 5)};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("run_rst_rdy", 32'(rdy), 32'd0);
    for (int p = 0; p < 3; p++) chk($sformatf("run_rst_o%0d", p), o[p], 32'h0);

    // Restart the clear sequence once the counter has reached 100.
    for (int n = 0; n < 100; n++) begin
      tick();
      chk("mid_clear_rdy", 32'(rdy), 32'd0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_rdy("restart", 1'b0);

    ra = {ad(3, 63), ad(2, 7), ad(1, 5)};
    tick();
    chk("after_restart_t1r5",  o[0], 32'h0);
    chk("after_restart_t2r7",  o[1], 32'h0);
    chk("after_restart_t3r63", o[2], 32'h0);
    chk("after_restart_rdy", 32'(rdy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
